// File: rtl/classify_scan_ctrl.sv
// Serial argmax/normalize controller: accepts one FC result vector, scans one class per cycle,
// then presents one-hot argmax, normalized vector, label score and saturating accuracy counters.
module classify_scan_ctrl #(
  parameter int unsigned CLASSIFICATIONS = 10,
  parameter int unsigned ELEMENT_SIZE    = 30,
  parameter int unsigned NORMALIZED_SIZE = 15,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0]    fc_results,
  input  logic [3:0]                                 label,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [CLASSIFICATIONS-1:0]                 class_hotcoded,
  output logic [3:0]                                 max_index,
  output logic [CLASSIFICATIONS*NORMALIZED_SIZE-1:0] normalized_results,
  output logic                                       correct,
  output logic                                       label_err,
  input  logic                                       clear_stats,
  output logic [COUNT_W-1:0]                         sample_count,
  output logic [COUNT_W-1:0]                         correct_count
);

  localparam int unsigned C = CLASSIFICATIONS;
  localparam int unsigned E = ELEMENT_SIZE;
  localparam int unsigned N = NORMALIZED_SIZE;
  localparam logic [E-1:0] Cutoff = {{(E-N){1'b0}}, {N{1'b1}}};

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e               state_q, state_d;
  logic [C*E-1:0]       fc_q, fc_d;
  logic [3:0]           label_q, label_d;
  logic [3:0]           idx_q, idx_d;
  logic [E-1:0]         max_val_q, max_val_d;
  logic [3:0]           max_idx_q, max_idx_d;
  logic [C*N-1:0]       norm_q, norm_d;
  logic [C-1:0]         hot_q, hot_d;
  logic [3:0]           max_index_q, max_index_d;
  logic                 correct_q, correct_d;
  logic                 label_err_q, label_err_d;
  logic [COUNT_W-1:0]   sample_q, sample_d;
  logic [COUNT_W-1:0]   correct_cnt_q, correct_cnt_d;

  logic [E-1:0]         elem;
  logic                 take;
  logic [3:0]           new_idx;
  logic [E-1:0]         new_val;
  logic [N-1:0]         norm_elem;
  logic                 new_lerr;

  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < C; i++) begin
      if (idx_q == 4'(i)) elem = fc_q[i*E +: E];
    end
    // Strict compare keeps the lowest index on ties.
    take      = (idx_q == 4'd0) || (elem > max_val_q);
    new_idx   = take ? idx_q : max_idx_q;
    new_val   = take ? elem : max_val_q;
    norm_elem = (elem > Cutoff) ? elem[E-1 -: N] : '0;
    new_lerr  = ({1'b0, label_q} >= 5'(C));
  end

  always_comb begin
    state_d       = state_q;
    fc_d          = fc_q;
    label_d       = label_q;
    idx_d         = idx_q;
    max_val_d     = max_val_q;
    max_idx_d     = max_idx_q;
    norm_d        = norm_q;
    hot_d         = hot_q;
    max_index_d   = max_index_q;
    correct_d     = correct_q;
    label_err_d   = label_err_q;
    sample_d      = sample_q;
    correct_cnt_d = correct_cnt_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          fc_d        = fc_results;
          label_d     = label;
          idx_d       = 4'd0;
          max_val_d   = '0;
          max_idx_d   = 4'd0;
          norm_d      = '0;
          hot_d       = '0;
          max_index_d = 4'd0;
          correct_d   = 1'b0;
          label_err_d = 1'b0;
          state_d     = StScan;
        end
      end
      StScan: begin
        max_val_d = new_val;
        max_idx_d = new_idx;
        for (int unsigned i = 0; i < C; i++) begin
          if (idx_q == 4'(i)) norm_d[i*N +: N] = norm_elem;
        end
        if (idx_q == 4'(C - 1)) begin
          for (int unsigned i = 0; i < C; i++) hot_d[i] = (new_idx == 4'(i));
          max_index_d = new_idx;
          label_err_d = new_lerr;
          correct_d   = !new_lerr && (new_idx == label_q);
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          if (sample_q != '1) sample_d = sample_q + 1'b1;
          if (correct_q && (correct_cnt_q != '1)) correct_cnt_d = correct_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear_stats) begin
      sample_d      = '0;
      correct_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      fc_q          <= '0;
      label_q       <= '0;
      idx_q         <= '0;
      max_val_q     <= '0;
      max_idx_q     <= '0;
      norm_q        <= '0;
      hot_q         <= '0;
      max_index_q   <= '0;
      correct_q     <= 1'b0;
      label_err_q   <= 1'b0;
      sample_q      <= '0;
      correct_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      fc_q          <= fc_d;
      label_q       <= label_d;
      idx_q         <= idx_d;
      max_val_q     <= max_val_d;
      max_idx_q     <= max_idx_d;
      norm_q        <= norm_d;
      hot_q         <= hot_d;
      max_index_q   <= max_index_d;
      correct_q     <= correct_d;
      label_err_q   <= label_err_d;
      sample_q      <= sample_d;
      correct_cnt_q <= correct_cnt_d;
    end
  end

  assign in_ready           = (state_q == StIdle);
  assign out_valid          = (state_q == StDone);
  assign class_hotcoded     = hot_q;
  assign max_index          = max_index_q;
  assign normalized_results = norm_q;
  assign correct            = correct_q;
  assign label_err          = label_err_q;
  assign sample_count       = sample_q;
  assign correct_count      = correct_cnt_q;

endmodule
